// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the fifo read-side engine: FSM encoding and queue depth.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam int QDEPTH = 2;

endpackage

// File: rtl/fifo_reader_sync_bit.sv
// Two-flop synchroniser, async active-low reset to 0.
module sync_bit (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine for the strobe-driven fifo: empty/get/out -> valid/ready stream.
// Optional drained-word counter enabled by defining FIFO_READER_COUNT_EN.
//
// state  | meaning
// IDLE   | sample empty_s, launch a get when a queue slot is free
// STROBE | fifo_get high, fifo latches its word on the rising edge
// HOLD   | fifo_get low, pointer advances; fifo_out pushed at end of cycle
// WAIT   | settle time so empty_s reflects the advanced pointer
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int W   = 8,
  parameter int GAP = 3
`ifdef FIFO_READER_COUNT_EN
  , parameter int CW = 16
`endif
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          fifo_empty,
  input  logic [W-1:0]  fifo_out,
  output logic          fifo_get,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
`ifdef FIFO_READER_COUNT_EN
  output logic [CW-1:0] count,
`endif
  input  logic          out_ready
);

  localparam int GW = $clog2(GAP + 1);

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic [1:0]      used;
  logic [W-1:0]    q1;
  logic            avail_s;
  logic            empty_s;
  logic            pending;
  logic            push;
  logic            pop;

  // Synchronise the inverted flag so the reset value of 0 reads as "empty".
  sync_bit u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (~fifo_empty),
    .q       (avail_s)
  );

  assign empty_s   = ~avail_s;
  assign pending   = (state == STROBE) || (state == HOLD);
  assign push      = (state == HOLD);
  assign out_valid = (used != 2'd0);
  assign pop       = out_valid && out_ready;

  // HOLD plus GAP-1 WAIT cycles give GAP low cycles before IDLE resamples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fifo_get <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty_s && ((used + {1'b0, pending}) < 2'(QDEPTH))) begin
            state    <= STROBE;
            fifo_get <= 1'b1;
          end
        end
        STROBE: begin
          state    <= HOLD;
          fifo_get <= 1'b0;
        end
        HOLD: begin
          state   <= WAIT;
          gap_cnt <= GW'(GAP - 2);
        end
        WAIT: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // out_data is the head entry; q1 is the second slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      used     <= 2'd0;
      out_data <= '0;
      q1       <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (used == 2'd0) out_data <= fifo_out;
          else              q1       <= fifo_out;
          used <= used + 2'd1;
        end
        2'b01: begin
          out_data <= q1;
          used     <= used - 2'd1;
        end
        2'b11: begin
          if (used == 2'd1) begin
            out_data <= fifo_out;
          end else begin
            out_data <= q1;
            q1       <= fifo_out;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (pop)  count <= count + CW'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader with a behavioural strobe-driven fifo model.
module tb_fifo_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       fifo_empty;
  logic [7:0] fifo_out;
  logic       fifo_get;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef FIFO_READER_COUNT_EN
  logic [3:0] count;
`endif

  always #5 clock = ~clock;

  fifo_reader #(
    .W   (8),
    .GAP (3)
`ifdef FIFO_READER_COUNT_EN
    , .CW (4)
`endif
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_out   (fifo_out),
    .fifo_get   (fifo_get),
    .out_data   (out_data),
    .out_valid  (out_valid),
`ifdef FIFO_READER_COUNT_EN
    .count      (count),
`endif
    .out_ready  (out_ready)
  );

  // Fifo model: word latched on rising get, pointer advances on falling get.
  logic [7:0] mem [64];
  int wr = 0;
  int rd = 0;
  assign fifo_empty = (rd == wr);
  always @(posedge fifo_get) fifo_out <= mem[rd % 64];
  always @(negedge fifo_get) rd <= rd + 1;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int rises [$];
  always @(posedge fifo_get) rises.push_back(cyc);

  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] w, input bit track);
    mem[wr % 64] = w;
    wr = wr + 1;
    if (track) exp_q.push_back(w);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name, input int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  int base;
  int t0;
  int n;
  bit got;

  initial begin
    fork
      begin : monitor
        int hi;
        hi = 0;
        forever begin
          @(negedge clock);
          if (reset_n && fifo_get) hi++;
          else if (hi > 0) begin
            chk("pulse_width", hi, 1);
            hi = 0;
          end
          if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
            else chk("data", int'(out_data), int'(exp_q.pop_front()));
          end
        end
      end
    join_none

    // 1: reset state, then reset asserted mid-STROBE
    reset_n   = 1'b0;
    out_ready = 1'b0;
    wait_cycles(3);
    chk("rst_get", int'(fifo_get), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    @(negedge clock);
    reset_n = 1'b1;
    load(8'h77, 1'b0);
    n = 0;
    for (int i = 0; i < 30 && n == 0; i++) begin
      @(posedge clock);
      #1;
      if (fifo_get) n = 1;
    end
    chk("rst_strobe_seen", n, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_get", int'(fifo_get), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    wait_cycles(2);
    @(negedge clock);
    reset_n = 1'b1;
    base = rises.size();
    wait_cycles(6);
    chk("rst_no_pulse", rises.size() - base, 0);
    chk("rst_still_empty", int'(out_valid), 0);

    // 2: single word and latency
    out_ready = 1'b1;
    base = rises.size();
    @(negedge clock);
    t0 = cyc;
    load(8'hA5, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (out_valid) got = 1'b1;
    end
    chk("single_timeout", int'(got), 1);
    if (got) begin
      chk("single_latency", cyc - t0, 5);
      chk("single_data", int'(out_data), 8'hA5);
    end
    wait_cycles(10);
    chk("single_pulses", rises.size() - base, 1);

    // 3: burst of four, pulse spacing
    base = rises.size();
    for (int i = 1; i <= 4; i++) load(8'(i), 1'b1);
    wait_drain("burst_drain", 100);
    wait_cycles(15);
    chk("burst_pulses", rises.size() - base, 4);
    for (int i = 1; i < 4; i++) chk("burst_spacing", rises[base+i] - rises[base+i-1], 5);

    // 4: backpressure with six words
    out_ready = 1'b0;
    base = rises.size();
    for (int i = 1; i <= 6; i++) load(8'h10 + 8'(i), 1'b1);
    wait_cycles(40);
    chk("bp_pulses", rises.size() - base, 2);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_head", int'(out_data), 8'h11);
    wait_cycles(5);
    chk("bp_head_stable", int'(out_data), 8'h11);
    out_ready = 1'b1;
    wait_drain("bp_drain", 200);
    wait_cycles(15);
    chk("bp_total_pulses", rises.size() - base, 6);

    // 5: pop coincides with HOLD push
    out_ready = 1'b0;
    load(8'h21, 1'b1);
    load(8'h22, 1'b1);
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(posedge clock);
      #1;
      if (fifo_get) n++;
    end
    chk("sim_pulses_seen", n, 2);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("sim_valid", int'(out_valid), 1);
    chk("sim_data", int'(out_data), 8'h22);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("sim_one_left", int'(out_valid), 0);
    chk("sim_sb_empty", exp_q.size(), 0);
    exp_q.delete();

`ifdef FIFO_READER_COUNT_EN
    // 6: counter wraps at 2**4
    @(negedge clock);
    reset_n = 1'b0;
    wait_cycles(2);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("cnt_reset", int'(count), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) load(8'h30 + 8'(i), 1'b1);
    wait_drain("cnt_drain", 400);
    wait_cycles(5);
    chk("cnt_wrap", int'(count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
